unary_sng_scheduler: RTL
========================

# unary_sng_scheduler

Round-robin scheduler that time-shares one 11-bit LFSR stochastic number generator (SNG) among NREQ requesters. Each granted job loads the requester's scalar and seed, then streams LEN unary bits serially, one per accepted beat, with valid/ready backpressure. At job end the block reports the final LFSR state so the requester can chain seeds across jobs. It sits between the hypervector encoders and the shared bitstream datapath.

## Interface

- NREQ, 4, number of requesters (≥2)
- LEN, 2048, bits per job (≥2)
- IW, $clog2(NREQ), requester index width (derived, not overridable)

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester job request, level
- scalar  in  NREQ*11  requester k at [11k+10:11k]
- seed  in  NREQ*11  requester k at [11k+10:11k]
- grant  out  NREQ  one-hot, high for the whole job (STREAM state)
- busy  out  1  high in STREAM and DONE
- bs_valid  out  1  stream bit valid
- bs_ready  in  1  downstream accepts bit
- bs_bit  out  1  unary bit
- bs_last  out  1  marks bit LEN-1
- bs_id  out  IW  index of granted requester
- done  out  1  one-cycle pulse after last bit accepted
- end_seed  out  11  LFSR state after LEN shifts, valid while done

## Operation

- LFSR step: tap = s[10]^s[3]^s[1]^s[0]; s <= {s[9:0], tap}.
- Bit i of a job = (scalar_r > s_i), unsigned 11-bit compare, where s_0 is the loaded seed and s_i is the state after i steps.
- Seed 0 is a lock-up state; on load, seed 11'h000 is replaced by 11'h001.
- FSM IDLE / STREAM / DONE:
  - IDLE: if |req, choose first set bit searching upward (with wrap) from ptr+1 modulo NREQ; register scalar_r, lfsr, bs_id, grant; cnt <= 0; ptr <= chosen index; go STREAM. If req==0, stay.
  - STREAM: bs_valid=1, bs_bit=(scalar_r>lfsr), bs_last=(cnt==LEN-1). On bs_valid&&bs_ready: step LFSR, cnt++; if bs_last, go DONE.
  - DONE: grant=0, bs_valid=0, done=1, end_seed=lfsr; go IDLE.
- req is sampled only in IDLE; dropping req mid-job has no effect (no abort). scalar/seed inputs are ignored after load.
- Requester still requesting after its job loses priority to any other requester (pointer fairness).
- cnt width $clog2(LEN); no wrap occurs since the job ends at LEN-1.
- Outputs when not in STREAM: bs_bit=0, bs_last=0; bs_id holds the last granted index; end_seed holds its value outside DONE.

## Timing

- Reset (rst high at edge): state IDLE, ptr=NREQ-1 (requester 0 highest priority), grant=0, busy=0, bs_valid=0, bs_bit=0, bs_last=0, bs_id=0, done=0, end_seed=0, cnt=0, lfsr=11'h001. Reset overrides everything, including mid-STREAM: the next cycle shows all reset values; the interrupted job is lost and is not resumed.
- req high at edge N in IDLE -> grant, busy, bs_valid, first bit all visible after edge N.
- bs_ready held high: bit i presented in cycle i of STREAM; bs_last is in cycle LEN-1; done is in cycle LEN; IDLE follows at LEN+1; next grant visible at LEN+2. Throughput is LEN bits per LEN+2 cycles.
- bs_ready low: bs_bit, bs_last, lfsr, and cnt are held stable; bs_valid stays high (no retraction).
- Outputs are registered state or a compare of registered state; there is no combinational path from req to any output. bs_ready feeds only next-state logic.

## Test plan

- Sequence check (LEN=8, req0, seed0=11'h001, scalar0=11'd2, bs_ready=1): LFSR states 1,3,6,…; bits 1,0,0,… Every bit matches a software model. end_seed equals model state after 8 steps. done pulses exactly once.
- Zero-seed substitution: seed 0 with scalar 2 -> bitstream identical to the seed-1 case. Scalar 0 -> all LEN bits 0.
- Round robin (LEN=8, req=4'b1111 held from reset): grant sequence 0,1,2,3,0. Each grant lasts 8 accepted beats. Grants are spaced 10 cycles apart.
- Backpressure: drop bs_ready for 3 cycles at bit 4 -> bs_bit and bs_last stay frozen with bs_valid high. The stream resumes at bit 4, and the total number of accepted beats is exactly LEN.
- Reset mid-stream: assert rst when cnt=5 -> next cycle all outputs equal reset values. With req=4'b1010 afterwards, requester 1 is granted first.
- req0 deasserted mid-job: the job still completes all LEN bits. bs_id stays 0 throughout and done pulses.

Source files
------------

// File: rtl/unary_sng_scheduler_if.sv
// Bitstream side of the SNG scheduler: serial unary bits with valid/ready,
// the granted requester id, and the end-of-job seed report.
interface unary_sng_scheduler_if #(
    parameter int NREQ = 4
) ();
    localparam int IW = $clog2(NREQ);

    logic          bs_valid;
    logic          bs_ready;
    logic          bs_bit;
    logic          bs_last;
    logic [IW-1:0] bs_id;
    logic          done;
    logic [10:0]   end_seed;

    modport master (
        output bs_valid, bs_bit, bs_last, bs_id, done, end_seed,
        input  bs_ready
    );

    modport slave (
        input  bs_valid, bs_bit, bs_last, bs_id, done, end_seed,
        output bs_ready
    );
endinterface

// File: rtl/unary_sng_scheduler.sv
// Round-robin scheduler sharing one 11-bit LFSR stochastic number generator
// among NREQ requesters; each job streams LEN unary bits then reports the LFSR state.
module unary_sng_scheduler #(
    parameter int NREQ = 4,
    parameter int LEN  = 2048
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*11-1:0]   scalar,
    input  logic [NREQ*11-1:0]   seed,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    unary_sng_scheduler_if.master bs
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(LEN);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] id_q, id_d;
    logic [10:0]   scalar_q, scalar_d;
    logic [10:0]   lfsr_q, lfsr_d;
    logic [10:0]   end_seed_q, end_seed_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          found;
    logic [IW-1:0] pick;
    logic [10:0]   seed_sel;
    logic          in_stream;
    logic          last_beat;

    function automatic logic [10:0] lfsr_next(input logic [10:0] s);
        return {s[9:0], s[10] ^ s[3] ^ s[1] ^ s[0]};
    endfunction

    // First requester above the pointer wins, so the last winner ranks lowest.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        for (int off = 1; off <= NREQ; off++) begin
            if (!found && req[(int'(ptr_q) + off) % NREQ]) begin
                found = 1'b1;
                pick  = IW'((int'(ptr_q) + off) % NREQ);
            end
        end
    end

    assign in_stream = (state_q == S_STREAM);
    assign last_beat = (cnt_q == CW'(LEN - 1));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        scalar_d   = scalar_q;
        lfsr_d     = lfsr_q;
        end_seed_d = end_seed_q;
        cnt_d      = cnt_q;
        seed_sel   = seed[int'(pick)*11 +: 11];
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d  = S_STREAM;
                    ptr_d    = pick;
                    id_d     = pick;
                    scalar_d = scalar[int'(pick)*11 +: 11];
                    // An all-zero LFSR never leaves zero, so substitute 1.
                    lfsr_d   = (seed_sel == 11'h000) ? 11'h001 : seed_sel;
                    cnt_d    = '0;
                end
            end
            S_STREAM: begin
                if (bs.bs_ready) begin
                    lfsr_d = lfsr_next(lfsr_q);
                    cnt_d  = cnt_q + CW'(1);
                    if (last_beat) begin
                        state_d    = S_DONE;
                        end_seed_d = lfsr_next(lfsr_q);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= IW'(NREQ - 1);
            id_q       <= '0;
            scalar_q   <= '0;
            lfsr_q     <= 11'h001;
            end_seed_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            scalar_q   <= scalar_d;
            lfsr_q     <= lfsr_d;
            end_seed_q <= end_seed_d;
            cnt_q      <= cnt_d;
        end
    end

    assign grant       = in_stream ? (NREQ'(1) << id_q) : '0;
    assign busy        = (state_q != S_IDLE);
    assign bs.bs_valid = in_stream;
    assign bs.bs_bit   = in_stream && (scalar_q > lfsr_q);
    assign bs.bs_last  = in_stream && last_beat;
    assign bs.bs_id    = id_q;
    assign bs.done     = (state_q == S_DONE);
    assign bs.end_seed = end_seed_q;
endmodule
